// File: rtl/text_render_pkg.sv
// Shared constants and FSM state type for the text-mode renderer.
package text_render_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 60;
  localparam int CELL_W = 8;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam int BLINK_HALF = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/text_render_ctrl_font_rom.sv
// Combinational 8x8 glyph ROM; rows 8..15 are blank for taller-font compatibility.
module font_rom (
  input  logic [7:0] char_code,
  input  logic [3:0] row,
  output logic [7:0] font_line
);

  always_comb begin
    font_line = 8'h00;
    if (!row[3]) begin
      case (char_code)
        8'h41: begin
          case (row[2:0])
            3'd0: font_line = 8'h18;
            3'd1: font_line = 8'h3C;
            3'd2: font_line = 8'h66;
            3'd3: font_line = 8'h66;
            3'd4: font_line = 8'h7E;
            3'd5: font_line = 8'h66;
            3'd6: font_line = 8'h66;
            default: font_line = 8'h00;
          endcase
        end
        8'h42: begin
          case (row[2:0])
            3'd0: font_line = 8'h7C;
            3'd1: font_line = 8'h66;
            3'd2: font_line = 8'h66;
            3'd3: font_line = 8'h7C;
            3'd4: font_line = 8'h66;
            3'd5: font_line = 8'h66;
            3'd6: font_line = 8'h7C;
            default: font_line = 8'h00;
          endcase
        end
        default: font_line = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/text_render_ctrl.sv
// Text-mode pixel renderer: character buffer, clear FSM, 3-cycle pixel pipeline.
// Optional blinking cursor enabled by defining TEXT_CURSOR_EN.
module text_render_ctrl
  import text_render_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       pix_out,
  output logic       pix_out_valid,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_col,
  input  logic [5:0] wr_row,
  input  logic [7:0] wr_char,
  input  logic       clr_start,
  output logic       clr_busy,
  input  logic       frame_tick,
  input  logic [6:0] cursor_col,
  input  logic [5:0] cursor_row
);

  localparam int DEPTH = COLS * ROWS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [6:0] COLS_C = 7'(COLS);
  localparam logic [6:0] ROWS_C = 7'(ROWS);
  localparam logic [9:0] X_LIMIT = 10'(COLS * CELL_W);
  localparam logic [9:0] Y_LIMIT = 10'(ROWS * CELL_W);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic              host_in_range;

  logic [6:0]        cell_col;
  logic [6:0]        cell_row;
  logic              pix_in_range;
  logic [ADDR_W-1:0] raddr;
  logic              cursor_hit;

  logic [7:0] text_mem [DEPTH];

  logic       vld_p0, vld_p1, vld_p2;
  logic [7:0] char_p0;
  logic       inrng_p0, inrng_p1;
  logic [2:0] bit_p0, bit_p1;
  logic [3:0] frow_p0;
  logic       cur_p0, cur_p1;
  logic [7:0] font_line;
  logic [7:0] line_p1;
  logic       pix_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    clr_busy = 1'b0;
    wr_ready = 1'b0;
    case (state_q)
      ST_IDLE:  wr_ready = 1'b1;
      ST_CLEAR: clr_busy = 1'b1;
      default:  wr_ready = 1'b0;
    endcase
  end

  // Clear owns the write port; gating with rst makes an aborted clear stop cleanly.
  assign host_in_range = (wr_col < COLS_C) && ({1'b0, wr_row} < ROWS_C);

  always_comb begin
    we    = 1'b0;
    waddr = clr_addr_q;
    wdata = CHAR_SPACE;
    if (!rst) begin
      if (clr_busy) begin
        we = 1'b1;
      end else if (wr_valid && wr_ready && host_in_range) begin
        we    = 1'b1;
        waddr = ADDR_W'(wr_row) * COLS_A + ADDR_W'(wr_col);
        wdata = wr_char;
      end
    end
  end

  assign cell_col     = pix_x[9:3];
  assign cell_row     = pix_y[9:3];
  assign pix_in_range = (pix_x < X_LIMIT) && (pix_y < Y_LIMIT);
  assign raddr        = pix_in_range ? (ADDR_W'(cell_row) * COLS_A + ADDR_W'(cell_col)) : '0;

`ifdef TEXT_CURSOR_EN
  localparam int BLINK_W = $clog2(BLINK_HALF);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_on_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        blink_on_q  <= ~blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  assign cursor_hit = blink_on_q && pix_in_range && (cell_col == cursor_col) &&
                      (cell_row == {1'b0, cursor_row}) && (pix_y[2:0] == 3'd7);
`else
  logic unused_cursor;
  assign unused_cursor = ^{frame_tick, cursor_col, cursor_row};
  assign cursor_hit    = 1'b0;
`endif

  // Stage 0: buffer read (read-first) plus pixel geometry.
  always_ff @(posedge clk) begin
    if (we) begin
      text_mem[waddr] <= wdata;
    end
    if (pix_valid) begin
      char_p0 <= text_mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    inrng_p0 <= pix_in_range;
    bit_p0   <= ~pix_x[2:0];
    frow_p0  <= {1'b0, pix_y[2:0]};
    cur_p0   <= cursor_hit;
  end

  font_rom u_font_rom (
    .char_code(char_p0),
    .row      (frow_p0),
    .font_line(font_line)
  );

  // Stage 1: glyph line captured.
  always_ff @(posedge clk) begin
    line_p1  <= font_line;
    inrng_p1 <= inrng_p0;
    bit_p1   <= bit_p0;
    cur_p1   <= cur_p0;
  end

  // Stage 2: pixel select; out-of-range pixels render background.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      pix_out_q <= 1'b0;
    end else begin
      vld_p0    <= pix_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      pix_out_q <= vld_p1 & inrng_p1 & (line_p1[bit_p1] | cur_p1);
    end
  end

  assign pix_out       = pix_out_q;
  assign pix_out_valid = vld_p2;

endmodule

// File: tb/tb_text_render_ctrl.sv
// Directed bench for text_render_ctrl: render, clear, bounds, read-first, reset abort, cursor.
module tb_text_render_ctrl;

`ifdef TEXT_CURSOR_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       pix_out;
  logic       pix_out_valid;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [6:0] wr_col = '0;
  logic [5:0] wr_row = '0;
  logic [7:0] wr_char = '0;
  logic       clr_start = 1'b0;
  logic       clr_busy;
  logic       frame_tick = 1'b0;
  logic [6:0] cursor_col = '0;
  logic [5:0] cursor_row = '0;

  int tests_run = 0;
  int tests_failed = 0;

  text_render_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_out      (pix_out),
    .pix_out_valid(pix_out_valid),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_col       (wr_col),
    .wr_row       (wr_row),
    .wr_char      (wr_char),
    .clr_start    (clr_start),
    .clr_busy     (clr_busy),
    .frame_tick   (frame_tick),
    .cursor_col   (cursor_col),
    .cursor_row   (cursor_row)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Single pixel request; result sampled 3 rising edges later, early reports any premature valid.
  task automatic pix_req(input logic [9:0] x, input logic [9:0] y,
                         output logic o, output logic v, output logic early);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_x = x;
    pix_y = y;
    @(negedge clk);
    pix_valid = 1'b0;
    early = pix_out_valid;
    @(negedge clk);
    early = early | pix_out_valid;
    @(negedge clk);
    o = pix_out;
    v = pix_out_valid;
  endtask

  task automatic host_wr(input logic [6:0] col, input logic [5:0] row,
                         input logic [7:0] ch, output logic accepted);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_col = col;
    wr_row = row;
    wr_char = ch;
    accepted = wr_ready;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    int seen;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (clr_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_clr_busy: got %b want 0", clr_busy); end
    tests_run++;
    if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    tests_run++;
    if (pix_out !== 1'b0 || pix_out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pix: pix_out=%b valid=%b want 0/0", pix_out, pix_out_valid);
    end
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (3) begin
      if (pix_out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL reset_flush: valid seen %0d times want 0", seen); end
  endtask

  task automatic test_write_render;
    logic acc, o, v, e;
    host_wr(7'd0, 6'd0, 8'h41, acc);
    tests_run++;
    if (acc !== 1'b1) begin tests_failed++; $display("FAIL wr_accept: wr_ready=%b want 1", acc); end
    pix_req(10'd3, 10'd0, o, v, e);
    tests_run++;
    if (o !== 1'b1 || v !== 1'b1) begin tests_failed++; $display("FAIL render_A_x3: out=%b valid=%b want 1/1", o, v); end
    tests_run++;
    if (e !== 1'b0) begin tests_failed++; $display("FAIL latency: valid early=%b want 0", e); end
    pix_req(10'd0, 10'd0, o, v, e);
    tests_run++;
    if (o !== 1'b0 || v !== 1'b1) begin tests_failed++; $display("FAIL render_A_x0: out=%b valid=%b want 0/1", o, v); end
    pix_req(10'd1, 10'd4, o, v, e);
    tests_run++;
    if (o !== 1'b1) begin tests_failed++; $display("FAIL render_A_row4: out=%b want 1", o); end
    pix_req(10'd5, 10'd0, o, v, e);
    tests_run++;
    if (o !== 1'b0) begin tests_failed++; $display("FAIL render_A_x5: out=%b want 0", o); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] line;
    logic exp_v;
    line = 8'b00011000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_v = (i >= 3) && (i < 11);
      tests_run++;
      if (pix_out_valid !== exp_v) begin
        tests_failed++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, pix_out_valid, exp_v);
      end else if (exp_v && pix_out !== line[7 - (i - 3)]) begin
        tests_failed++; $display("FAIL b2b_pix[%0d]: got %b want %b", i, pix_out, line[7 - (i - 3)]);
      end
      pix_valid = (i < 8);
      pix_x = 10'(i);
      pix_y = 10'd0;
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_clear;
    int cnt, rdy_seen, lit;
    logic o, v, e;
    @(negedge clk);
    clr_start = 1'b1;
    tests_run++;
    if (clr_busy !== 1'b0) begin tests_failed++; $display("FAIL clr_busy_early: got %b want 0", clr_busy); end
    @(negedge clk);
    clr_start = 1'b0;
    cnt = 0;
    rdy_seen = 0;
    while (clr_busy === 1'b1 && cnt < 6000) begin
      cnt++;
      if (wr_ready !== 1'b0) rdy_seen++;
      wr_valid  = (cnt >= 10 && cnt < 12);
      wr_col    = 7'd0;
      wr_row    = 6'd0;
      wr_char   = 8'h41;
      clr_start = (cnt == 20);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    clr_start = 1'b0;
    tests_run++;
    if (cnt != 4800) begin tests_failed++; $display("FAIL clr_busy_len: got %0d cycles want 4800", cnt); end
    tests_run++;
    if (rdy_seen != 0) begin tests_failed++; $display("FAIL clr_wr_ready: high %0d cycles want 0", rdy_seen); end
    lit = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        pix_req(10'(c), 10'(r), o, v, e);
        if (o !== 1'b0 || v !== 1'b1) lit++;
      end
    end
    tests_run++;
    if (lit != 0) begin tests_failed++; $display("FAIL clr_cell0: %0d bad pixels want 0", lit); end
  endtask

  task automatic test_out_of_range;
    logic acc, o, v, e;
    host_wr(7'd0, 6'd0, 8'h41, acc);
    pix_req(10'd643, 10'd0, o, v, e);
    tests_run++;
    if (o !== 1'b0 || v !== 1'b1) begin tests_failed++; $display("FAIL oor_x: out=%b valid=%b want 0/1", o, v); end
    pix_req(10'd3, 10'd480, o, v, e);
    tests_run++;
    if (o !== 1'b0 || v !== 1'b1) begin tests_failed++; $display("FAIL oor_y: out=%b valid=%b want 0/1", o, v); end
    host_wr(7'd80, 6'd0, 8'h41, acc);
    tests_run++;
    if (acc !== 1'b1) begin tests_failed++; $display("FAIL oor_wr_accept: wr_ready=%b want 1", acc); end
    pix_req(10'd3, 10'd8, o, v, e);
    tests_run++;
    if (o !== 1'b0) begin tests_failed++; $display("FAIL oor_wr_ignored: cell(0,1) out=%b want 0", o); end
  endtask

  task automatic test_same_cycle;
    logic o, v, e;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_col = 7'd5;
    wr_row = 6'd5;
    wr_char = 8'h41;
    pix_valid = 1'b1;
    pix_x = 10'd41;
    pix_y = 10'd44;
    @(negedge clk);
    wr_valid = 1'b0;
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (pix_out !== 1'b0 || pix_out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL read_first_old: out=%b valid=%b want 0/1", pix_out, pix_out_valid);
    end
    pix_req(10'd41, 10'd44, o, v, e);
    tests_run++;
    if (o !== 1'b1) begin tests_failed++; $display("FAIL read_first_new: out=%b want 1", o); end
  endtask

  task automatic test_reset_mid_clear;
    logic acc, o, v, e;
    host_wr(7'd19, 6'd1, 8'h41, acc);
    host_wr(7'd20, 6'd1, 8'h41, acc);
    @(negedge clk);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (clr_busy !== 1'b0 || wr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL abort_ctrl: clr_busy=%b wr_ready=%b want 0/1", clr_busy, wr_ready);
    end
    pix_req(10'd155, 10'd8, o, v, e);
    tests_run++;
    if (o !== 1'b0) begin tests_failed++; $display("FAIL abort_cell99: out=%b want 0", o); end
    pix_req(10'd163, 10'd8, o, v, e);
    tests_run++;
    if (o !== 1'b1) begin tests_failed++; $display("FAIL abort_cell100: out=%b want 1", o); end
    pix_req(10'd3, 10'd0, o, v, e);
    tests_run++;
    if (o !== 1'b0) begin tests_failed++; $display("FAIL abort_cell0: out=%b want 0", o); end
    pix_req(10'd41, 10'd44, o, v, e);
    tests_run++;
    if (o !== 1'b1) begin tests_failed++; $display("FAIL abort_cell405: out=%b want 1", o); end
  endtask

  task automatic test_cursor;
    logic o, v, e;
    cursor_col = 7'd2;
    cursor_row = 6'd1;
    repeat (32) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
    for (int x = 16; x < 24; x++) begin
      pix_req(10'(x), 10'd15, o, v, e);
      tests_run++;
      if (o !== CUR_EN) begin tests_failed++; $display("FAIL cursor_on[x=%0d]: out=%b want %b", x, o, CUR_EN); end
    end
    pix_req(10'd16, 10'd14, o, v, e);
    tests_run++;
    if (o !== 1'b0) begin tests_failed++; $display("FAIL cursor_row6: out=%b want 0", o); end
    repeat (32) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
    pix_req(10'd16, 10'd15, o, v, e);
    tests_run++;
    if (o !== 1'b0) begin tests_failed++; $display("FAIL cursor_off: out=%b want 0", o); end
  endtask

  initial begin
    test_reset();
    test_write_render();
    test_back_to_back();
    test_clear();
    test_out_of_range();
    test_same_cycle();
    test_reset_mid_clear();
    test_cursor();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
